// File: rtl/score_pkg.sv
// Shared constants, types and helpers for the score keeper and its BCD converter.
package score_pkg;

  localparam int unsigned DEF_SCORE_W   = 10;
  localparam int unsigned DEF_MAX_SCORE = 999;
  localparam int unsigned DEF_DIGITS    = 3;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Hit/miss inputs and score outputs between the duck logic and the score keeper.
interface score_keeper_if
  import score_pkg::*;
#(
  parameter int unsigned N_SRC   = 2,
  parameter int unsigned SCORE_W = DEF_SCORE_W,
  parameter int unsigned DIGITS  = DEF_DIGITS
);
  logic                  round_clr;
  logic [N_SRC-1:0]      hit;
  logic                  miss;
  logic [SCORE_W-1:0]    score;
  logic [SCORE_W-1:0]    high_score;
  logic                  new_high;
  logic                  saturated;
  logic [4*DIGITS-1:0]   score_bcd;
  logic                  bcd_busy;

  modport master (
    output round_clr, hit, miss,
    input  score, high_score, new_high, saturated, score_bcd, bcd_busy
  );

  modport slave (
    input  round_clr, hit, miss,
    output score, high_score, new_high, saturated, score_bcd, bcd_busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: IDLE -> SHIFT (SCORE_W cycles) -> DONE -> IDLE.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int unsigned SCORE_W = DEF_SCORE_W,
  parameter int unsigned DIGITS  = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = clog2(SCORE_W + 1);

  conv_state_e        state_q, state_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   acc_q, acc_d, adj_c, bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  bcd_digit_t         dig_c;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    dig_c   = '0;
    adj_c   = acc_q;
    // Add-3 on every digit that would overflow past 9 when doubled.
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig_c = acc_q[4*i +: 4];
      if (dig_c >= 4'd5) adj_c[4*i +: 4] = dig_c + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          bin_d   = bin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        {acc_d, bin_d} = {adj_c, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_keeper.sv
// Saturating multi-duck score counter with session high score and BCD readout.
// Optional macro SCORE_PENALTY_EN: a miss rising edge subtracts PENALTY (floored at 0).
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned N_SRC       = 2,
  parameter int unsigned SCORE_W     = DEF_SCORE_W,
  parameter int unsigned PTS_PER_HIT = 1,
  parameter int unsigned MAX_SCORE   = DEF_MAX_SCORE,
  parameter int unsigned DIGITS      = DEF_DIGITS,
  parameter int unsigned PENALTY     = 1
) (
  input logic           clk,
  input logic           rst,
  score_keeper_if.slave sk
);
  localparam int unsigned INC_W = SCORE_W + clog2(N_SRC) + 1;
  localparam int unsigned NET_W = INC_W + 1;
  localparam int unsigned BCD_W = 4 * DIGITS;
`ifdef SCORE_PENALTY_EN
  localparam bit PEN_EN = 1'b1;
`else
  localparam bit PEN_EN = 1'b0;
`endif
  localparam int unsigned DEC = PEN_EN ? PENALTY : 32'd0;

  logic [N_SRC-1:0]        hit_q, hit_d, rise_c;
  logic                    armed_q, armed_d;
  logic                    miss_rise_c;
  logic [SCORE_W-1:0]      score_q, score_d, high_q, high_d, last_q, last_d;
  logic                    new_high_q, new_high_d, sat_q, sat_d, pending_q, pending_d;
  logic [INC_W-1:0]        inc_c;
  logic signed [NET_W-1:0] net_c;
  logic                    start_c, conv_busy, conv_done;
  logic [BCD_W-1:0]        conv_bcd;

`ifdef SCORE_PENALTY_EN
  logic miss_q, miss_d;
  assign miss_d      = sk.miss;
  assign miss_rise_c = armed_q & sk.miss & ~miss_q;

  always_ff @(posedge clk) begin
    if (rst) miss_q <= 1'b0;
    else     miss_q <= miss_d;
  end
`else
  assign miss_rise_c = 1'b0;
`endif

  always_comb begin
    hit_d   = sk.hit;
    armed_d = 1'b1;
    // First cycle after reset only captures levels, so inputs held high through reset never count.
    rise_c  = armed_q ? (sk.hit & ~hit_q) : '0;
    inc_c   = INC_W'($countones(rise_c)) * INC_W'(PTS_PER_HIT);
    net_c   = NET_W'(score_q) + NET_W'(inc_c) - (miss_rise_c ? NET_W'(DEC) : NET_W'(0));

    if (sk.round_clr)                            score_d = '0;
    else if (net_c[NET_W-1])                     score_d = '0;
    else if (net_c > $signed(NET_W'(MAX_SCORE))) score_d = SCORE_W'(MAX_SCORE);
    else                                         score_d = SCORE_W'(net_c);

    high_d     = high_q;
    new_high_d = 1'b0;
    if (score_q > high_q) begin
      high_d     = score_q;
      new_high_d = 1'b1;
    end
    sat_d = (score_d == SCORE_W'(MAX_SCORE));

    // One conversion in flight at a time; latest score is picked up once it retires.
    start_c   = !pending_q && (score_q != last_q);
    pending_d = pending_q;
    last_d    = last_q;
    if (conv_done) pending_d = 1'b0;
    if (start_c) begin
      pending_d = 1'b1;
      last_d    = score_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q      <= '0;
      armed_q    <= 1'b0;
      score_q    <= '0;
      high_q     <= '0;
      last_q     <= '0;
      new_high_q <= 1'b0;
      sat_q      <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      hit_q      <= hit_d;
      armed_q    <= armed_d;
      score_q    <= score_d;
      high_q     <= high_d;
      last_q     <= last_d;
      new_high_q <= new_high_d;
      sat_q      <= sat_d;
      pending_q  <= pending_d;
    end
  end

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .bin   (score_q),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign sk.score      = score_q;
  assign sk.high_score = high_q;
  assign sk.new_high   = new_high_q;
  assign sk.saturated  = sat_q;
  assign sk.score_bcd  = conv_bcd;
  assign sk.bcd_busy   = conv_busy;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (1 and 5 points per hit) against a behavioural model.
// Works with or without SCORE_PENALTY_EN defined.
module tb_score_keeper;
  localparam int unsigned N_SRC = 2;
  localparam int unsigned W     = 10;
  localparam int unsigned MAXS  = 999;
  localparam int unsigned DIG   = 3;
  localparam int unsigned PEN   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] hit_r;
  logic       miss_r, clr_r;

  int n_checks = 0;
  int n_err    = 0;

  int m_score[2], m_high[2], m_nh[2], m_sat[2], m_bcd[2], m_rem[2], m_last[2], m_conv[2];
  logic [1:0] m_hit_prev;
  bit         m_miss_prev, m_fresh;

  score_keeper_if #(.N_SRC(N_SRC), .SCORE_W(W), .DIGITS(DIG)) bus1 ();
  score_keeper_if #(.N_SRC(N_SRC), .SCORE_W(W), .DIGITS(DIG)) bus5 ();

  assign bus1.hit = hit_r;  assign bus1.miss = miss_r;  assign bus1.round_clr = clr_r;
  assign bus5.hit = hit_r;  assign bus5.miss = miss_r;  assign bus5.round_clr = clr_r;

  score_keeper #(.N_SRC(N_SRC), .SCORE_W(W), .PTS_PER_HIT(1), .MAX_SCORE(MAXS),
                 .DIGITS(DIG), .PENALTY(PEN)) u_dut1 (.clk(clk), .rst(rst), .sk(bus1));
  score_keeper #(.N_SRC(N_SRC), .SCORE_W(W), .PTS_PER_HIT(5), .MAX_SCORE(MAXS),
                 .DIGITS(DIG), .PENALTY(PEN)) u_dut5 (.clk(clk), .rst(rst), .sk(bus5));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic int pts_of(input int k);
    return (k == 0) ? 1 : 5;
  endfunction

  function automatic int to_bcd(input int v);
    int r, x;
    r = 0;
    x = v;
    for (int d = 0; d < int'(DIG); d++) begin
      r = r | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs the DUT just sampled.
  task automatic model_step();
    int n, sp, ns;
    bit mr;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_score[k] = 0; m_high[k] = 0; m_nh[k] = 0; m_sat[k] = 0;
        m_bcd[k] = 0; m_rem[k] = 0; m_last[k] = 0; m_conv[k] = 0;
      end
      m_hit_prev = '0; m_miss_prev = 1'b0; m_fresh = 1'b1;
      return;
    end
    n = 0;
    for (int i = 0; i < 2; i++) if (hit_r[i] && !m_hit_prev[i] && !m_fresh) n++;
    mr = 1'b0;
`ifdef SCORE_PENALTY_EN
    mr = miss_r && !m_miss_prev && !m_fresh;
`endif
    for (int k = 0; k < 2; k++) begin
      sp = m_score[k];
      m_nh[k] = (sp > m_high[k]) ? 1 : 0;
      if (sp > m_high[k]) m_high[k] = sp;
      if (clr_r) ns = 0;
      else begin
        ns = sp + n * pts_of(k) - (mr ? int'(PEN) : 0);
        if (ns < 0) ns = 0;
        if (ns > int'(MAXS)) ns = int'(MAXS);
      end
      m_score[k] = ns;
      m_sat[k]   = (ns == int'(MAXS)) ? 1 : 0;
      // Conversion occupies W shift cycles plus one load cycle after it is launched.
      if (m_rem[k] > 0) begin
        m_rem[k]--;
        if (m_rem[k] == 0) m_bcd[k] = to_bcd(m_conv[k]);
      end else if (sp != m_last[k]) begin
        m_conv[k] = sp;
        m_last[k] = sp;
        m_rem[k]  = int'(W) + 1;
      end
    end
    m_hit_prev  = hit_r;
    m_miss_prev = miss_r;
    m_fresh     = 1'b0;
  endtask

  task automatic check_model();
    chk("score_p1",     int'(bus1.score),      m_score[0]);
    chk("high_p1",      int'(bus1.high_score), m_high[0]);
    chk("new_high_p1",  int'(bus1.new_high),   m_nh[0]);
    chk("saturated_p1", int'(bus1.saturated),  m_sat[0]);
    chk("bcd_p1",       int'(bus1.score_bcd),  m_bcd[0]);
    chk("busy_p1",      int'(bus1.bcd_busy),   (m_rem[0] > 0) ? 1 : 0);
    chk("score_p5",     int'(bus5.score),      m_score[1]);
    chk("high_p5",      int'(bus5.high_score), m_high[1]);
    chk("new_high_p5",  int'(bus5.new_high),   m_nh[1]);
    chk("saturated_p5", int'(bus5.saturated),  m_sat[1]);
    chk("bcd_p5",       int'(bus5.score_bcd),  m_bcd[1]);
    chk("busy_p5",      int'(bus5.bcd_busy),   (m_rem[1] > 0) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    tick(); tick();
    while (c < 100 && !(bus1.bcd_busy == 1'b0 && bus5.bcd_busy == 1'b0 &&
                        m_rem[0] == 0 && m_rem[1] == 0 &&
                        m_last[0] == m_score[0] && m_last[1] == m_score[1])) begin
      tick();
      c++;
    end
    chk("idle_reached", int'(bus1.bcd_busy) + int'(bus5.bcd_busy) + ((c >= 100) ? 1 : 0), 0);
  endtask

  task automatic do_reset(input logic [1:0] hold_hit);
    rst = 1'b1; hit_r = hold_hit; miss_r = 1'b0; clr_r = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic pulse_hit(input logic [1:0] h);
    hit_r = h;     tick();
    hit_r = 2'b00; tick();
  endtask

  initial begin
    int pulses1, pulses5, pulse_iter;

    // Reset with both hit lines held high: nothing counts at release.
    rst = 1'b1; hit_r = 2'b11; miss_r = 1'b0; clr_r = 1'b0;
    tick(); tick();
    chk("rst_score", int'(bus1.score), 0);
    chk("rst_bcd",   int'(bus1.score_bcd), 0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("held_hit_ignored", int'(bus1.score), 0);
    hit_r = 2'b00; tick(); tick();

    // Single hit held for three cycles counts once; BCD follows after W+2 cycles.
    hit_r = 2'b01; tick();
    chk("single_score_p1", int'(bus1.score), 1);
    for (int c = 1; c <= 11; c++) begin
      if (c == 3) hit_r = 2'b00;
      if (c == 1) chk("single_new_high", int'(bus1.new_high), 0);
      tick();
      if (c == 1) chk("single_new_high_pulse", int'(bus1.new_high), 1);
    end
    chk("bcd_not_early", int'(bus1.score_bcd), 0);
    tick();
    chk("single_bcd_p1",  int'(bus1.score_bcd), 'h001);
    chk("single_bcd_p5",  int'(bus5.score_bcd), 'h005);
    chk("single_high_p1", int'(bus1.high_score), 1);

    // Simultaneous hits on both ducks.
    do_reset(2'b00);
    hit_r = 2'b11; tick();
    chk("simul_score_p5", int'(bus5.score), 10);
    chk("simul_score_p1", int'(bus1.score), 2);
    hit_r = 2'b00;
    wait_idle();
    chk("simul_bcd_p5", int'(bus5.score_bcd), 'h010);

    // Saturation at MAX_SCORE.
    do_reset(2'b00);
    for (int i = 0; i < 99; i++) pulse_hit(2'b11);
    pulse_hit(2'b01);
    chk("preload_p5", int'(bus5.score), 995);
    chk("preload_sat", int'(bus5.saturated), 0);
    for (int i = 0; i < 3; i++) pulse_hit(2'b10);
    chk("sat_score_p5", int'(bus5.score), 999);
    chk("sat_flag_p5",  int'(bus5.saturated), 1);
    chk("sat_flag_p1",  int'(bus1.saturated), 0);
    wait_idle();
    chk("sat_bcd_p5", int'(bus5.score_bcd), 'h999);
    chk("sat_bcd_p1", int'(bus1.score_bcd), 'h202);

    // Round clear beats a simultaneous hit and leaves the high score alone.
    do_reset(2'b00);
    for (int i = 0; i < 7; i++) pulse_hit(2'b01);
    chk("pre_clr_p1", int'(bus1.score), 7);
    hit_r = 2'b01; clr_r = 1'b1; tick();
    chk("clr_score_p1", int'(bus1.score), 0);
    chk("clr_score_p5", int'(bus5.score), 0);
    hit_r = 2'b00; clr_r = 1'b0; tick();
    chk("clr_high_p1", int'(bus1.high_score), 7);
    chk("clr_no_pulse", int'(bus1.new_high), 0);
    pulses1 = 0; pulses5 = 0; pulse_iter = 0;
    for (int i = 1; i <= 8; i++) begin
      hit_r = 2'b01; tick();
      pulses1 += int'(bus1.new_high); pulses5 += int'(bus5.new_high);
      hit_r = 2'b00; tick();
      pulses1 += int'(bus1.new_high); pulses5 += int'(bus5.new_high);
      if (bus1.new_high) pulse_iter = i;
    end
    chk("rc_pulses_p1", pulses1, 1);
    chk("rc_pulses_p5", pulses5, 1);
    chk("rc_pulse_iter", pulse_iter, 8);

    // Two score changes while a conversion is running.
    wait_idle();
    hit_r = 2'b01; tick();
    hit_r = 2'b00; tick(); tick();
    hit_r = 2'b01; tick();
    chk("ovr_busy", int'(bus1.bcd_busy), 1);
    hit_r = 2'b00;
    wait_idle();
    chk("ovr_bcd_p1", int'(bus1.score_bcd), 'h010);
    chk("ovr_bcd_p5", int'(bus5.score_bcd), 'h050);

    // Miss handling.
    do_reset(2'b00);
    pulse_hit(2'b01);
    miss_r = 1'b1; tick();
    miss_r = 1'b0; tick();
`ifdef SCORE_PENALTY_EN
    chk("miss_floor_p1", int'(bus1.score), 0);
    chk("miss_p5",       int'(bus5.score), 3);
`else
    chk("miss_ignored_p1", int'(bus1.score), 1);
    chk("miss_ignored_p5", int'(bus5.score), 5);
`endif
    for (int i = 0; i < 4; i++) pulse_hit(2'b01);
    hit_r = 2'b01; miss_r = 1'b1; tick();
    hit_r = 2'b00; miss_r = 1'b0; tick();
`ifdef SCORE_PENALTY_EN
    chk("hit_miss_p1", int'(bus1.score), 3);
    chk("hit_miss_p5", int'(bus5.score), 26);
    chk("pen_keeps_high", int'(bus1.high_score), 4);
`else
    chk("hit_miss_p1", int'(bus1.score), 6);
    chk("hit_miss_p5", int'(bus5.score), 30);
`endif

    // Random traffic, including occasional clears and resets mid-conversion.
    for (int i = 0; i < 600; i++) begin
      hit_r  = 2'($urandom_range(0, 3));
      miss_r = 1'($urandom_range(0, 1));
      clr_r  = ($urandom_range(0, 24) == 0);
      rst    = ($urandom_range(0, 120) == 0);
      tick();
    end
    rst = 1'b0; clr_r = 1'b0; hit_r = 2'b00; miss_r = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Parametrised successor to the game's single-duck score counter.
- Counts hits from N_SRC independent duck targets, all in the clk domain, and saturates at MAX_SCORE.
- Tracks a session high score and supplies a registered BCD image of the score to the on-screen text/digit renderer.
- Sits between the duck/hit-detection logic and the VGA overlay.

Parameters:
- N_SRC, 2, number of hit-source lines (ducks).
- SCORE_W, 10, binary width of score and high_score.
- PTS_PER_HIT, 1, points added per detected hit.
- MAX_SCORE, 999, saturation ceiling; must be less than 2**SCORE_W.
- DIGITS, 3, BCD digits produced; 10**DIGITS must exceed MAX_SCORE.
- PENALTY, 1, points removed per miss (feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; clears everything.
- round_clr  in  1  new-round clear; zeroes score only.
- hit  in  N_SRC  per-duck hit level, synchronous to clk; one hit = rising edge.
- miss  in  1  shot-with-no-hit level (mouse click), synchronous; rising edge counts.
- score  out  SCORE_W  current score, registered.
- high_score  out  SCORE_W  session maximum, registered.
- new_high  out  1  one-cycle pulse when high_score increases.
- saturated  out  1  high while score == MAX_SCORE.
- score_bcd  out  4*DIGITS  BCD of the last converted score, least-significant digit in [3:0].
- bcd_busy  out  1  conversion in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: score, high_score, score_bcd = 0; new_high, saturated, bcd_busy = 0; edge-detect registers = 0. Hit levels already high when rst releases are not counted.
- Edge detect:
  - rise[i] = hit[i] & ~hit_q[i], with hit_q registered every cycle, including during round_clr.
  - Same scheme for miss.
- Score update, one cycle after the rising edge:
  - Increment = popcount(rise) * PTS_PER_HIT, computed at width SCORE_W+clog2(N_SRC)+1 so there is no overflow.
  - next = min(score + increment, MAX_SCORE).
  - Simultaneous hits on several ducks all count.
- Priority: rst > round_clr > hits/miss. round_clr sets score to 0 and discards any edges in that cycle. It does not touch high_score.
- High score:
  - If the updated score is greater than high_score, high_score takes the updated score one cycle after score changes, and new_high pulses in that same cycle.
  - Equal scores do not pulse.
- saturated is derived combinationally from the score register (score == MAX_SCORE).
- BCD converter: sequential shift-add-3 (double dabble).
  - Starts in IDLE when score differs from the last converted value.
  - States: IDLE -> SHIFT (SCORE_W cycles) -> DONE (1 cycle, loads score_bcd) -> IDLE.
  - Latency from score change to score_bcd update is SCORE_W+2 cycles. bcd_busy is high during SHIFT and DONE.
  - A score change during conversion is not lost: the in-flight conversion completes, then a new one starts from the current score, so only the latest value is guaranteed.
  - rst mid-conversion returns the converter to IDLE with score_bcd = 0.
  - round_clr does not abort a conversion; the follow-up conversion produces 0.

Optional Feature:
- Macro: SCORE_PENALTY_EN.
- Defined:
  - A miss rising edge subtracts PENALTY, floored at 0.
  - Net change in a cycle = increment - PENALTY, applied once; the result is clamped to the range [0, MAX_SCORE].
  - A penalty never lowers high_score.
- Undefined: the miss port exists but is ignored, and no miss edge register is synthesised.

Decomposition:
- Package score_pkg:
  - Default constants: SCORE_W, MAX_SCORE, DIGITS.
  - BCD digit typedef: 4-bit logic.
  - Converter state typedef: enum IDLE/SHIFT/DONE.
  - clog2 helper function.
- One sub-module: bin2bcd_seq (parameters SCORE_W, DIGITS).
  - Ports: clk, rst, start, bin, busy, done, bcd.
  - score_keeper wraps the converter and holds the pending/last-converted bookkeeping.

Test Plan:
- Reset then single hit: rst 2 cycles; pulse hit[0] high for 3 cycles -> score = 1 once; new_high pulse; high_score = 1; score_bcd = 12'h001 after SCORE_W+2 cycles.
- Simultaneous hits, PTS_PER_HIT=5: hit = 2'b11 rising in the same cycle -> score 0 -> 10 in one step; score_bcd = 12'h010.
- Saturation: preload to 995 via hits, then apply 3 more edges with PTS_PER_HIT=5 -> score sticks at 999; saturated = 1; score_bcd = 12'h999.
- Round clear: score 7, high 7; round_clr together with a hit edge -> score 0, hit ignored, high_score 7, no new_high pulse. Then 8 hits -> new_high pulses only on the 8th.
- BCD overrun: two score changes 3 cycles apart while bcd_busy -> final score_bcd equals the final score, and bcd_busy deasserts.
- SCORE_PENALTY_EN: score 1, PENALTY=2, miss edge -> score 0. Hit and miss in the same cycle at score 4 with PTS_PER_HIT=1 -> score 3. Macro undefined -> miss has no effect.
